uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter: 5-9 data bits, optional odd/even parity, 1 or 2 stop bits.
//  Has a FIFO_DEPTH-entry input FIFO, so a bus-side writer can queue words.
//  Sends back-to-back frames with no idle gap.
//  Sits between the AHB UART register slave and the TX pin.
// PARAMETERS
//  CLKS_PER_BIT  217  i_Clock cycles per serial bit (>=2); 25 MHz / 115200 baud
//  DATA_BITS     8    data bits per frame, 5..9, sent LSB first
//  PARITY        0    0 = none, 1 = odd, 2 = even
//  STOP_BITS     1    1 or 2
//  FIFO_DEPTH    4    input FIFO entries, power of 2, >=2
// PORTS
//  i_Clock         in   1                        system clock, rising edge
//  i_Rst_L         in   1                        asynchronous, active-low reset
//  i_TX_DV         in   1                        write strobe; accepted when o_TX_Ready=1
//  i_TX_Byte       in   DATA_BITS                word to queue
//  o_TX_Ready      out  1                        FIFO not full
//  o_TX_Overrun    out  1                        1-cycle pulse: write dropped because FIFO full
//  o_FIFO_Count    out  $clog2(FIFO_DEPTH)+1     queued words, excluding the word in flight
//  o_TX_Active     out  1                        frame in progress
//  o_TX_Serial     out  1                        serial line, idle high
//  o_TX_Done       out  1                        1-cycle pulse at end of each frame
//  i_TX_Break      in   1                        present only with UART_TX_BREAK_EN
// BEHAVIOUR
//  Reset (i_Rst_L=0, async):
//   - o_TX_Serial=1; o_TX_Active, o_TX_Done, o_TX_Overrun=0; o_FIFO_Count=0; o_TX_Ready=1.
//   - FSM goes to IDLE; FIFO pointers clear.
//   - Mid-frame reset aborts the frame and forces the line high immediately; queued words are lost.
//  Push: i_TX_DV=1 and o_TX_Ready=1 writes i_TX_Byte at the FIFO tail.
//   - i_TX_DV=1 with o_TX_Ready=0: word dropped, o_TX_Overrun pulses the next cycle.
//   - o_TX_Ready is count-registered; a pop in the same cycle does not make a full FIFO ready.
//   - Push and pop in the same cycle: count unchanged.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE|START.
//   - IDLE: line high. If FIFO non-empty, pop the head into the shift register and go to START.
//     o_TX_Active=1 from the same edge.
//   - START: line 0. DATA: bit[i] for i = 0..DATA_BITS-1. PARITY: present when PARITY!=0.
//     STOP: line 1 for STOP_BITS bit periods.
//   - Every bit lasts exactly CLKS_PER_BIT cycles. Baud counter width is $clog2(CLKS_PER_BIT);
//     it wraps to 0 at CLKS_PER_BIT-1.
//   - Parity: even = XOR of data bits; odd = its inverse.
//   - End of the last stop-bit period: o_TX_Done pulses for 1 cycle.
//     If the FIFO is non-empty, pop and go straight to START (0 idle cycles);
//     o_TX_Active stays 1.
//     Else go to IDLE; o_TX_Active drops to 0 on the same edge.
//  Latency: push into an empty FIFO while IDLE -> line falls 2 cycles later (1 cycle FIFO, 1 cycle pop).
//  Frame length: CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
//  Unused or illegal state -> IDLE. All outputs are registered.
// CONFIGURATION
//  UART_TX_BREAK_EN defined:
//   - Adds port i_TX_Break.
//   - While i_TX_Break=1: o_TX_Serial=0 and the FSM holds in IDLE; no pops, FIFO pushes still accepted.
//   - Raising i_TX_Break mid-frame waits for the current frame to finish (o_TX_Done pulses),
//     then the line goes low.
//   - After i_TX_Break falls, the line is held high for one full bit period before the next START.
//  UART_TX_BREAK_EN undefined: port absent; line is low only during start, data and parity bits.
// TESTING (CLKS_PER_BIT=4 unless noted)
//  - 8N1, push 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; o_TX_Done pulses once at cycle 40.
//  - PARITY=2 then PARITY=1, 0xA5 -> parity bit 0 (even) / 1 (odd); frame is 44 cycles.
//  - 7E2 (DATA_BITS=7, STOP_BITS=2), push 0x55 -> 0, 1010101, parity 0, 1, 1; 44 cycles.
//  - Depth 4: push 6 words in 6 consecutive cycles -> 5 words accepted
//    (1 popped + 4 queued), 1 o_TX_Overrun pulse.
//    5 frames sent back-to-back, no gap; 5 o_TX_Done pulses; o_TX_Active stays high throughout.
//  - Deassert i_Rst_L at cycle 17 of a frame -> o_TX_Serial=1 and o_FIFO_Count=0 at once;
//    no o_TX_Done pulse.
//  - UART_TX_BREAK_EN: i_TX_Break held 20 cycles while IDLE -> line low 20 cycles, then high;
//    a queued word's START begins 4 cycles after i_TX_Break falls.

Source files
------------

// File: rtl/uart_tx_cfg_if.sv
// Word-queue side of the UART transmitter: write strobe/data in, FIFO status and serial line out.
// The slave modport is the transmitter; the master modport is the bus-side writer.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 i_TX_DV;
  logic [DATA_BITS-1:0] i_TX_Byte;
  logic                 o_TX_Ready;
  logic                 o_TX_Overrun;
  logic [CW-1:0]        o_FIFO_Count;
  logic                 o_TX_Active;
  logic                 o_TX_Serial;
  logic                 o_TX_Done;

  modport master (
    output i_TX_DV, i_TX_Byte,
    input  o_TX_Ready, o_TX_Overrun, o_FIFO_Count, o_TX_Active, o_TX_Serial, o_TX_Done
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte,
    output o_TX_Ready, o_TX_Overrun, o_FIFO_Count, o_TX_Active, o_TX_Serial, o_TX_Done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with input FIFO; frames go out back-to-back with no idle gap.
// Optional line-break control is compiled in with UART_TX_BREAK_EN (adds port i_TX_Break).
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
`ifdef UART_TX_BREAK_EN
  input  logic i_TX_Break,
`endif
  uart_tx_cfg_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_ready, r_overrun;

  state_t               r_state;
  logic [BW-1:0]        r_baud;
  logic [3:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic                 r_serial, r_active, r_done;

  logic                 w_push, w_pop, w_bit_end, w_last_stop, w_brk_block, w_head_par;
  logic [CW-1:0]        w_count_next;
  logic [DATA_BITS-1:0] w_head;

`ifdef UART_TX_BREAK_EN
  // r_brk_seen stays set from break entry until one full high bit period has elapsed
  logic r_brk_seen;
  assign w_brk_block = i_TX_Break | r_brk_seen;
`else
  assign w_brk_block = 1'b0;
`endif

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_par  = ^w_head;
  assign w_push      = bus.i_TX_DV & r_ready;
  assign w_bit_end   = (r_baud == BAUD_MAX);
  assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit_idx == LAST_STOP);
  assign w_pop       = (r_count != '0) && !w_brk_block && ((r_state == S_IDLE) || w_last_stop);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.i_TX_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ready   <= 1'b1;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count   <= w_count_next;
      r_ready   <= (w_count_next != FULL);
      r_overrun <= bus.i_TX_DV & ~r_ready;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state    <= S_IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_serial   <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      r_brk_seen <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
      // A pop loads the head word and starts the start bit on the same edge
      if (w_pop) begin
        r_state   <= S_START;
        r_serial  <= 1'b0;
        r_active  <= 1'b1;
        r_shift   <= w_head;
        r_parity  <= (PARITY == 1) ? ~w_head_par : w_head_par;
        r_bit_idx <= '0;
      end
      case (r_state)
        S_IDLE: begin
          r_baud    <= '0;
          r_bit_idx <= '0;
          if (!w_pop) begin
            r_serial <= 1'b1;
            r_active <= 1'b0;
          end
`ifdef UART_TX_BREAK_EN
          if (i_TX_Break) begin
            r_serial   <= 1'b0;
            r_brk_seen <= 1'b1;
          end else if (r_brk_seen) begin
            if (r_baud == BAUD_MAX) r_brk_seen <= 1'b0;
            else                    r_baud     <= r_baud + 1'b1;
          end
`endif
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_serial  <= r_shift[0];
            r_bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == LAST_DATA) begin
              r_bit_idx <= '0;
              if (PARITY != 0) begin
                r_state  <= S_PARITY;
                r_serial <= r_parity;
              end else begin
                r_state  <= S_STOP;
                r_serial <= 1'b1;
              end
            end else begin
              r_serial  <= r_shift[1];
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state   <= S_STOP;
            r_serial  <= 1'b1;
            r_bit_idx <= '0;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (r_bit_idx == LAST_STOP) begin
              r_done <= 1'b1;
              if (!w_pop) begin
                r_state  <= S_IDLE;
                r_active <= 1'b0;
                r_serial <= 1'b1;
`ifdef UART_TX_BREAK_EN
                if (i_TX_Break) begin
                  r_serial   <= 1'b0;
                  r_brk_seen <= 1'b1;
                end
`endif
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_serial <= 1'b1;
          r_active <= 1'b0;
          r_baud   <= '0;
        end
      endcase
    end
  end

  assign bus.o_TX_Ready   = r_ready;
  assign bus.o_TX_Overrun = r_overrun;
  assign bus.o_FIFO_Count = r_count;
  assign bus.o_TX_Active  = r_active;
  assign bus.o_TX_Serial  = r_serial;
  assign bus.o_TX_Done    = r_done;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four instances (8N1, 8E1, 8O1, 7E2) at CLKS_PER_BIT=4, depth 4.
// Expected frames are built by a small model and queued when words are pushed.
module tb_uart_tx_cfg;
  localparam int N     = 4;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  function automatic int db_of(int k);
    return (k == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(int k);
    case (k)
      1: return 2;
      2: return 1;
      3: return 2;
      default: return 0;
    endcase
  endfunction
  function automatic int sb_of(int k);
    return (k == 3) ? 2 : 1;
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] dv = '0;
  logic [8:0]   tx_word = '0;
  logic         brk = 1'b0;
  logic [N-1:0] serial, done, active, ready, overrun;
  logic [2:0]   cnt [N];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         k;
    logic [15:0] bits;
    int         len;
  } frame_t;
  frame_t sb[$];

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    uart_tx_cfg_if #(.DATA_BITS(db_of(gi)), .FIFO_DEPTH(DEPTH)) bus ();
    uart_tx_cfg #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(db_of(gi)), .PARITY(par_of(gi)),
      .STOP_BITS(sb_of(gi)), .FIFO_DEPTH(DEPTH)
    ) dut (
      .i_Clock(clk),
      .i_Rst_L(rst_n),
`ifdef UART_TX_BREAK_EN
      .i_TX_Break(brk),
`endif
      .bus(bus)
    );
    assign bus.i_TX_DV   = dv[gi];
    assign bus.i_TX_Byte = tx_word[db_of(gi)-1:0];
    assign serial[gi]    = bus.o_TX_Serial;
    assign done[gi]      = bus.o_TX_Done;
    assign active[gi]    = bus.o_TX_Active;
    assign ready[gi]     = bus.o_TX_Ready;
    assign overrun[gi]   = bus.o_TX_Overrun;
    assign cnt[gi]       = bus.o_FIFO_Count;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t make_frame(int k, logic [8:0] w);
    frame_t f;
    int     p;
    logic   x;
    f.k    = k;
    f.bits = '1;
    f.bits[0] = 1'b0;
    x = 1'b0;
    for (int i = 0; i < db_of(k); i++) begin
      f.bits[1+i] = w[i];
      x = x ^ w[i];
    end
    p = 1 + db_of(k);
    if (par_of(k) != 0) begin
      f.bits[p] = (par_of(k) == 2) ? x : ~x;
      p++;
    end
    for (int s = 0; s < sb_of(k); s++) begin
      f.bits[p] = 1'b1;
      p++;
    end
    f.len = p;
    return f;
  endfunction

  task automatic push_one(int k, logic [8:0] w, bit accept);
    dv[k]   = 1'b1;
    tx_word = w;
    tick();
    dv[k]   = 1'b0;
    if (accept) sb.push_back(make_frame(k, w));
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (serial !== 4'b1111) begin errors++; $display("FAIL reset_serial got %b want 1111", serial); end
    checks++; if (active !== 4'b0000) begin errors++; $display("FAIL reset_active got %b want 0000", active); end
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b want 0000", done); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL reset_overrun got %b want 0000", overrun); end
    checks++; if (ready !== 4'b1111) begin errors++; $display("FAIL reset_ready got %b want 1111", ready); end
    for (int k = 0; k < N; k++) begin
      checks++; if (cnt[k] !== 3'd0) begin errors++; $display("FAIL reset_count dut%0d got %0d want 0", k, cnt[k]); end
    end
    rst_n = 1'b1;
    repeat (2) tick();
    $display("reset: checked %0d instances", N);
  endtask

  task automatic test_frame_format(int k, logic [8:0] w, string name);
    frame_t f;
    int     lat, in_done, bad_bits;
    bit     ok;
    logic   bad_val;
    push_one(k, w, 1'b1);
    checks++; if (cnt[k] !== 3'd1) begin errors++; $display("FAIL %s_count_after_push got %0d want 1", name, cnt[k]); end
    lat = 0;
    while (serial[k] !== 1'b0 && lat < 8) begin tick(); lat++; end
    checks++; if (lat !== 1) begin errors++; $display("FAIL %s_latency got %0d want 1", name, lat); end
    checks++; if (active[k] !== 1'b1) begin errors++; $display("FAIL %s_active_start got %b want 1", name, active[k]); end
    f = sb.pop_front();
    in_done = 0;
    bad_bits = 0;
    ok = 1'b1;
    bad_val = 1'b0;
    for (int n = 0; n < f.len * CPB; n++) begin
      if (n % CPB == 0) ok = 1'b1;
      if (serial[k] !== f.bits[n/CPB]) begin ok = 1'b0; bad_val = serial[k]; end
      if (done[k] === 1'b1) in_done++;
      if (n % CPB == CPB - 1) begin
        checks++;
        if (!ok) begin
          errors++; bad_bits++;
          $display("FAIL %s_bit%0d got %b want %b", name, n / CPB, bad_val, f.bits[n/CPB]);
        end
      end
      tick();
    end
    checks++; if (done[k] !== 1'b1) begin errors++; $display("FAIL %s_done_at_end got %b want 1", name, done[k]); end
    checks++; if (in_done !== 0) begin errors++; $display("FAIL %s_early_done got %0d pulses want 0", name, in_done); end
    tick();
    checks++; if (done[k] !== 1'b0) begin errors++; $display("FAIL %s_done_width got %b want 0", name, done[k]); end
    checks++; if (active[k] !== 1'b0 || serial[k] !== 1'b1) begin
      errors++; $display("FAIL %s_idle_after active %b serial %b want 0 1", name, active[k], serial[k]);
    end
    $display("%s: word %h frame %0d bits, %0d bad bits", name, w, f.len, bad_bits);
  endtask

  task automatic test_back_to_back;
    logic [8:0] words [6];
    logic       ln [0:255];
    logic       dn [0:255];
    logic       ac [0:255];
    logic       rd [0:255];
    logic [2:0] ct [0:255];
    int         ncap, ov, base, dpat, apat, dcount;
    bit         ok;
    frame_t     f;
    words = '{9'h0A5, 9'h03C, 9'h0FF, 9'h000, 9'h081, 9'h077};
    ncap = 0; ov = 0;
    for (int i = 0; i < 6; i++) begin
      dv[0] = 1'b1; tx_word = words[i];
      tick();
      if (i < 5) sb.push_back(make_frame(0, words[i]));
      if (i == 1) begin
        checks++; if (cnt[0] !== 3'd1) begin errors++; $display("FAIL b2b_push_pop_count got %0d want 1", cnt[0]); end
      end
      if (i == 4) begin
        checks++; if (cnt[0] !== 3'd4) begin errors++; $display("FAIL b2b_full_count got %0d want 4", cnt[0]); end
        checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", ready[0]); end
      end
      if (i == 5) begin
        checks++; if (overrun[0] !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", overrun[0]); end
      end
      if (overrun[0] === 1'b1) ov++;
      if (i >= 1) begin
        ln[ncap] = serial[0]; dn[ncap] = done[0]; ac[ncap] = active[0];
        rd[ncap] = ready[0]; ct[ncap] = cnt[0]; ncap++;
      end
    end
    dv[0] = 1'b0;
    while (ncap < 5 * 40 + 3) begin
      tick();
      if (overrun[0] === 1'b1) ov++;
      ln[ncap] = serial[0]; dn[ncap] = done[0]; ac[ncap] = active[0];
      rd[ncap] = ready[0]; ct[ncap] = cnt[0]; ncap++;
    end
    checks++; if (ov !== 1) begin errors++; $display("FAIL b2b_overrun_pulses got %0d want 1", ov); end
    checks++; if (rd[39] !== 1'b0) begin errors++; $display("FAIL b2b_ready_before_pop got %b want 0", rd[39]); end
    checks++; if (rd[40] !== 1'b1 || ct[40] !== 3'd3) begin
      errors++; $display("FAIL b2b_after_pop ready %b count %0d want 1 3", rd[40], ct[40]);
    end
    base = 0;
    for (int fr = 0; fr < 5; fr++) begin
      f = sb.pop_front();
      ok = 1'b1;
      for (int n = 0; n < f.len * CPB; n++)
        if (ln[base+n] !== f.bits[n/CPB]) ok = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL b2b_frame%0d line pattern wrong, want word %h", fr, words[fr]); end
      base += f.len * CPB;
    end
    dpat = 0; apat = 0; dcount = 0;
    for (int n = 0; n < ncap; n++) begin
      if (dn[n] === 1'b1) dcount++;
      if (dn[n] !== ((n > 0) && (n % 40 == 0) && (n <= 200))) dpat++;
      if (ac[n] !== (n < 200)) apat++;
    end
    checks++; if (dcount !== 5) begin errors++; $display("FAIL b2b_done_count got %0d want 5", dcount); end
    checks++; if (dpat !== 0) begin errors++; $display("FAIL b2b_done_timing got %0d wrong cycles want 0", dpat); end
    checks++; if (apat !== 0) begin errors++; $display("FAIL b2b_active got %0d wrong cycles want 0", apat); end
    $display("back_to_back: 6 pushed, %0d overrun, %0d done pulses", ov, dcount);
  endtask

  task automatic test_mid_frame_reset;
    int dcount, lows;
    dcount = 0;
    dv[0] = 1'b1;
    tx_word = 9'h000; tick();
    tx_word = 9'h00F; tick();
    tx_word = 9'h033; tick();
    dv[0] = 1'b0;
    repeat (15) begin
      tick();
      if (done[0] === 1'b1) dcount++;
    end
    checks++; if (serial[0] !== 1'b0 || cnt[0] !== 3'd2) begin
      errors++; $display("FAIL rst_pre serial %b count %0d want 0 2", serial[0], cnt[0]);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (serial[0] !== 1'b1) begin errors++; $display("FAIL rst_async_serial got %b want 1", serial[0]); end
    checks++; if (cnt[0] !== 3'd0) begin errors++; $display("FAIL rst_async_count got %0d want 0", cnt[0]); end
    checks++; if (active[0] !== 1'b0 || ready[0] !== 1'b1) begin
      errors++; $display("FAIL rst_async_flags active %b ready %b want 0 1", active[0], ready[0]);
    end
    repeat (3) begin
      tick();
      if (done[0] === 1'b1) dcount++;
    end
    rst_n = 1'b1;
    lows = 0;
    repeat (50) begin
      tick();
      if (done[0] === 1'b1) dcount++;
      if (serial[0] !== 1'b1) lows++;
    end
    checks++; if (dcount !== 0) begin errors++; $display("FAIL rst_no_done got %0d pulses want 0", dcount); end
    checks++; if (lows !== 0) begin errors++; $display("FAIL rst_words_lost got %0d low cycles want 0", lows); end
    $display("mid_frame_reset: line forced high, queue flushed");
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break;
    int     lows, hi;
    frame_t f;
    bit     ok;
    brk = 1'b1;
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin dv[0] = 1'b1; tx_word = 9'h05A; end
      tick();
      if (i == 5) begin dv[0] = 1'b0; sb.push_back(make_frame(0, 9'h05A)); end
      if (serial[0] === 1'b0) lows++;
    end
    checks++; if (lows !== 20) begin errors++; $display("FAIL brk_low_cycles got %0d want 20", lows); end
    checks++; if (cnt[0] !== 3'd1) begin errors++; $display("FAIL brk_push_held got %0d want 1", cnt[0]); end
    brk = 1'b0;
    hi = 0;
    tick();
    while (serial[0] === 1'b1 && hi < 10) begin hi++; tick(); end
    checks++; if (hi !== 4) begin errors++; $display("FAIL brk_guard got %0d high cycles want 4", hi); end
    f = sb.pop_front();
    ok = 1'b1;
    for (int n = 0; n < f.len * CPB; n++) begin
      if (serial[0] !== f.bits[n/CPB]) ok = 1'b0;
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL brk_frame line pattern wrong, want word 05a"); end
    checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL brk_done got %b want 1", done[0]); end
    tick();
    $display("break: %0d low cycles, %0d guard cycles", lows, hi);
  endtask
`endif

  initial begin
    test_reset();
    test_frame_format(0, 9'h0A5, "8N1");
    test_frame_format(1, 9'h0A5, "8E1");
    test_frame_format(2, 9'h0A5, "8O1");
    test_frame_format(3, 9'h055, "7E2");
    test_back_to_back();
    test_mid_frame_reset();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
